// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/stop control and a one-cycle done pulse.
// State, digits and status flags are all registered and share one synchronous clear.
module countdown_timer #(
  parameter int unsigned MIN_T_MAX = 5
) (
  input  logic       clkmain,
  input  logic       clear,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_u,
  input  logic [2:0] ld_sec_t,
  input  logic [3:0] ld_sec_u,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0] MIN_T_LIM = 4'(MIN_T_MAX);

  state_t     state, state_nx;
  logic [3:0] min_t_nx, min_u_nx, sec_u_nx;
  logic [2:0] sec_t_nx;
  logic       pulse_nx;
  logic       count_zero, count_one;

  assign count_zero = (min_t == 4'd0) && (min_u == 4'd0) && (sec_t == 3'd0) && (sec_u == 4'd0);
  assign count_one  = (min_t == 4'd0) && (min_u == 4'd0) && (sec_t == 3'd0) && (sec_u == 4'd1);

  // Priority ladder: load > stop > start > tick (clear is handled in the register).
  always_comb begin
    // NOTE: every signal gets a default before the if-ladder, so no path leaves it unassigned and no latch is inferred.
    state_nx = state;
    min_t_nx = min_t;
    min_u_nx = min_u;
    sec_t_nx = sec_t;
    sec_u_nx = sec_u;
    pulse_nx = 1'b0;

    if (load && state != RUN) begin
      min_t_nx = (ld_min_t > MIN_T_LIM) ? MIN_T_LIM : ld_min_t;
      min_u_nx = (ld_min_u > 4'd9) ? 4'd9 : ld_min_u;
      sec_t_nx = (ld_sec_t > 3'd5) ? 3'd5 : ld_sec_t;
      sec_u_nx = (ld_sec_u > 4'd9) ? 4'd9 : ld_sec_u;
      state_nx = IDLE;
    end else if (stop && state == RUN) begin
      state_nx = PAUSE;
    end else if (start && (state == IDLE || state == PAUSE) && !count_zero) begin
      state_nx = RUN;
    end else if (tick && state == RUN) begin
      // RUN always holds a nonzero count, so the borrow chain never underflows min_t.
      if (sec_u != 4'd0) begin
        sec_u_nx = sec_u - 4'd1;
      end else begin
        sec_u_nx = 4'd9;
        if (sec_t != 3'd0) begin
          sec_t_nx = sec_t - 3'd1;
        end else begin
          sec_t_nx = 3'd5;
          if (min_u != 4'd0) begin
            min_u_nx = min_u - 4'd1;
          end else begin
            min_u_nx = 4'd9;
            min_t_nx = min_t - 4'd1;
          end
        end
      end
      if (count_one) begin
        state_nx = DONE;
        pulse_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clkmain) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (clear) begin
      state      <= IDLE;
      min_t      <= 4'd0;
      min_u      <= 4'd0;
      sec_t      <= 3'd0;
      sec_u      <= 4'd0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      min_t      <= min_t_nx;
      min_u      <= min_u_nx;
      sec_t      <= sec_t_nx;
      sec_u      <= sec_u_nx;
      running    <= (state_nx == RUN);
      done       <= (state_nx == DONE);
      done_pulse <= pulse_nx;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed vector table, corner sequences,
// and random stimulus against a seconds-based reference model.
module tb_countdown_timer;

  localparam int MIN_T_MAX = 5;

  logic       clkmain = 1'b0;
  logic       clear = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] ld_min_t = '0, ld_min_u = '0, ld_sec_u = '0;
  logic [2:0] ld_sec_t = '0;
  logic [3:0] min_t, min_u, sec_u;
  logic [2:0] sec_t;
  logic       running, done, done_pulse;

  countdown_timer #(.MIN_T_MAX(MIN_T_MAX)) dut (
    .clkmain(clkmain), .clear(clear), .tick(tick), .load(load),
    .ld_min_t(ld_min_t), .ld_min_u(ld_min_u), .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
    .start(start), .stop(stop),
    .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
    .running(running), .done(done), .done_pulse(done_pulse)
  );

  always #5 clkmain = ~clkmain;

  int errors = 0;
  int checks = 0;

  // Observed outputs packed as {min_t, min_u, sec_t, sec_u, running, done, done_pulse}.
  logic [17:0] dut_vec;
  assign dut_vec = {min_t, min_u, sec_t, sec_u, running, done, done_pulse};

  // Reference model: count kept as total seconds.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_total = 0;
  bit      m_pulse = 1'b0;

  function automatic logic [17:0] ev(input int mt, input int mu, input int st, input int su,
                                     input logic [2:0] fl);
    return {4'(mt), 4'(mu), 3'(st), 4'(su), fl};
  endfunction

  function automatic logic [17:0] model_vec();
    int mins, secs;
    mins = m_total / 60;
    secs = m_total % 60;
    return ev(mins / 10, mins % 10, secs / 10, secs % 10,
              {m_state == M_RUN, m_state == M_DONE, m_pulse});
  endfunction

  function automatic int lim(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  task automatic model_step(input logic c, input logic l, input logic s, input logic p,
                            input logic t, input int a, input int b, input int cc, input int d);
    m_pulse = 1'b0;
    if (c) begin
      m_state = M_IDLE;
      m_total = 0;
    end else if (l && m_state != M_RUN) begin
      m_total = (lim(a, MIN_T_MAX) * 10 + lim(b, 9)) * 60 + lim(cc, 5) * 10 + lim(d, 9);
      m_state = M_IDLE;
    end else if (p && m_state == M_RUN) begin
      m_state = M_PAUSE;
    end else if (s && (m_state == M_IDLE || m_state == M_PAUSE) && m_total > 0) begin
      m_state = M_RUN;
    end else if (t && m_state == M_RUN) begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_state = M_DONE;
        m_pulse = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got mm:ss=%h%h:%h%h r/d/p=%b%b%b, expected mm:ss=%h%h:%h%h r/d/p=%b%b%b",
               name, act[17:14], act[13:10], act[9:7], act[6:3], act[2], act[1], act[0],
               exp[17:14], exp[13:10], exp[9:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ctl = {clear, load, start, stop, tick}; inputs held across one rising edge, outputs read 1 ns later.
  task automatic apply(input logic [4:0] ctl, input int a = 0, input int b = 0,
                       input int cc = 0, input int d = 0);
    {clear, load, start, stop, tick} = ctl;
    ld_min_t = 4'(a);
    ld_min_u = 4'(b);
    ld_sec_t = 3'(cc);
    ld_sec_u = 4'(d);
    @(posedge clkmain);
    model_step(ctl[4], ctl[3], ctl[2], ctl[1], ctl[0], a, b, cc, d);
    #1;
    {clear, load, start, stop, tick} = 5'b0;
  endtask

  typedef struct packed {
    logic [4:0]  ctl;
    logic [3:0]  lmt, lmu;
    logic [2:0]  lst;
    logic [3:0]  lsu;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] ctl, input int lmt, input int lmu, input int lst,
                     input int lsu, input int emt, input int emu, input int est, input int esu,
                     input logic [2:0] fl);
    tbl.push_back('{ctl, 4'(lmt), 4'(lmu), 3'(lst), 4'(lsu), ev(emt, emu, est, esu, fl)});
  endtask

  initial begin
    // ctl bits: clear load start stop tick | load digits | expected digits | running done pulse
    add(5'b10000, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000);  // reset state
    add(5'b01000, 0, 1, 0, 0,  0, 1, 0, 0, 3'b000);  // load 01:00
    add(5'b00100, 0, 0, 0, 0,  0, 1, 0, 0, 3'b100);  // start
    add(5'b00001, 0, 0, 0, 0,  0, 0, 5, 9, 3'b100);  // borrow to 00:59
    add(5'b01000, 3, 3, 3, 3,  0, 0, 5, 9, 3'b100);  // load ignored in RUN
    add(5'b00110, 0, 0, 0, 0,  0, 0, 5, 9, 3'b000);  // stop+start -> PAUSE
    add(5'b00001, 0, 0, 0, 0,  0, 0, 5, 9, 3'b000);  // tick ignored in PAUSE
    add(5'b00101, 0, 0, 0, 0,  0, 0, 5, 9, 3'b100);  // start+tick: tick ignored
    add(5'b00001, 0, 0, 0, 0,  0, 0, 5, 8, 3'b100);
    add(5'b00011, 0, 0, 0, 0,  0, 0, 5, 8, 3'b000);  // stop+tick: tick ignored
    add(5'b01000, 7, 9, 7, 9,  5, 9, 5, 9, 3'b000);  // clamp min_t, sec_t
    add(5'b01000, 3, 12, 6, 15, 3, 9, 5, 9, 3'b000); // clamp min_u, sec_t, sec_u
    add(5'b01000, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000);  // load 00:00
    add(5'b00100, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000);  // start at zero ignored
    add(5'b01000, 1, 0, 0, 0,  1, 0, 0, 0, 3'b000);  // load 10:00
    add(5'b00100, 0, 0, 0, 0,  1, 0, 0, 0, 3'b100);
    add(5'b00001, 0, 0, 0, 0,  0, 9, 5, 9, 3'b100);  // full borrow ripple
    add(5'b01000, 0, 0, 0, 1,  0, 9, 5, 9, 3'b100);  // load ignored in RUN
    add(5'b00010, 0, 0, 0, 0,  0, 9, 5, 9, 3'b000);
    add(5'b01000, 0, 0, 0, 1,  0, 0, 0, 1, 3'b000);  // load honoured in PAUSE
    add(5'b00100, 0, 0, 0, 0,  0, 0, 0, 1, 3'b100);
    add(5'b00001, 0, 0, 0, 0,  0, 0, 0, 0, 3'b011);  // enter DONE with pulse
    add(5'b00000, 0, 0, 0, 0,  0, 0, 0, 0, 3'b010);  // pulse lasts one cycle
    add(5'b00100, 0, 0, 0, 0,  0, 0, 0, 0, 3'b010);  // start ignored in DONE
    add(5'b00001, 0, 0, 0, 0,  0, 0, 0, 0, 3'b010);  // no wrap below zero
    add(5'b01000, 0, 0, 0, 2,  0, 0, 0, 2, 3'b000);  // load leaves DONE
    add(5'b01000, 0, 2, 3, 1,  0, 2, 3, 1, 3'b000);
    add(5'b00100, 0, 0, 0, 0,  0, 2, 3, 1, 3'b100);
    add(5'b00001, 0, 0, 0, 0,  0, 2, 3, 0, 3'b100);  // mid-RUN at 02:30
    add(5'b11101, 5, 5, 5, 5,  0, 0, 0, 0, 3'b000);  // clear beats load/start/tick
    add(5'b01000, 0, 0, 1, 0,  0, 0, 1, 0, 3'b000);
    add(5'b00010, 0, 0, 0, 0,  0, 0, 1, 0, 3'b000);  // stop in IDLE: no effect
    add(5'b00100, 0, 0, 0, 0,  0, 0, 1, 0, 3'b100);
    add(5'b10000, 0, 0, 0, 0,  0, 0, 0, 0, 3'b000);  // clear mid-RUN

    foreach (tbl[i]) begin
      apply(tbl[i].ctl, tbl[i].lmt, tbl[i].lmu, tbl[i].lst, tbl[i].lsu);
      check($sformatf("table[%0d]", i), dut_vec, tbl[i].exp);
    end

    // Full minute countdown to DONE.
    apply(5'b10000);
    apply(5'b01000, 0, 1, 0, 0);
    apply(5'b00100);
    apply(5'b00001);
    check("minute_first_tick", dut_vec, ev(0, 0, 5, 9, 3'b100));
    for (int i = 0; i < 58; i++) begin
      apply(5'b00001);
      check($sformatf("minute_tick[%0d]", i), dut_vec, model_vec());
    end
    apply(5'b00001);
    check("minute_done", dut_vec, ev(0, 0, 0, 0, 3'b011));
    apply(5'b00000);
    check("minute_pulse_end", dut_vec, ev(0, 0, 0, 0, 3'b010));

    // Pause/resume around a short countdown.
    apply(5'b01000, 0, 0, 0, 5);
    apply(5'b00100);
    apply(5'b00001);
    apply(5'b00001);
    check("pause_run_2", dut_vec, ev(0, 0, 0, 3, 3'b100));
    apply(5'b00010);
    check("pause_enter", dut_vec, ev(0, 0, 0, 3, 3'b000));
    for (int i = 0; i < 3; i++) apply(5'b00001);
    check("pause_hold", dut_vec, ev(0, 0, 0, 3, 3'b000));
    apply(5'b00100);
    check("pause_resume", dut_vec, ev(0, 0, 0, 3, 3'b100));
    apply(5'b00001);
    apply(5'b00001);
    check("pause_run_1", dut_vec, ev(0, 0, 0, 1, 3'b100));
    apply(5'b00001);
    check("pause_done", dut_vec, ev(0, 0, 0, 0, 3'b011));

    // Random stimulus against the reference model.
    apply(5'b10000);
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] ctl;
      int a, b, cc, d;
      ctl[4] = ($urandom_range(0, 63) == 0);
      ctl[3] = ($urandom_range(0, 15) == 0);
      ctl[2] = ($urandom_range(0, 7) == 0);
      ctl[1] = !ctl[2] && ($urandom_range(0, 15) == 0);
      ctl[0] = $urandom_range(0, 1) == 1;
      a  = $urandom_range(0, 1) == 1 ? 0 : $urandom_range(0, 15);
      b  = $urandom_range(0, 1) == 1 ? 0 : $urandom_range(0, 15);
      cc = $urandom_range(0, 7);
      d  = $urandom_range(0, 15);
      apply(ctl, a, b, cc, d);
      check($sformatf("random[%0d]", i), dut_vec, model_vec());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MIN_T_MAX, default 5, SHALL set the largest legal minutes-tens digit (range 1..9).
REQ-002 clkmain  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 clear  input  1  reset, synchronous and active-high; it SHALL be sampled on the rising clkmain edge only.
REQ-004 tick  input  1  one-cycle 1 Hz enable pulse; each high cycle is one decrement request.
REQ-005 load  input  1  when high, SHALL copy ld_min_t/ld_min_u/ld_sec_t/ld_sec_u into the count.
REQ-006 ld_min_t 4, ld_min_u 4, ld_sec_t 3, ld_sec_u 4  inputs  BCD preset digits.
REQ-007 start  input  1  level, sampled each cycle; begins or resumes the countdown.
REQ-008 stop  input  1  level, sampled each cycle; pauses the countdown.
REQ-009 min_t 4, min_u 4, sec_t 3, sec_u 4  outputs  registered BCD digits of the current count (MM:SS).
REQ-010 running  output  1  high while the state is RUN.
REQ-011 done  output  1  high while the state is DONE.
REQ-012 done_pulse  output  1  one-cycle pulse on the clock edge that enters DONE.

Function
REQ-013 The block SHALL implement the states IDLE, RUN, PAUSE and DONE; all outputs SHALL be registered.
REQ-014 Priority per edge SHALL be clear > load > stop > start > tick.
REQ-015 load SHALL be honoured in IDLE, PAUSE and DONE; the next state SHALL be IDLE and done SHALL drop.
REQ-016 load SHALL be ignored in RUN.
REQ-017 On load, any digit above its limit (min_t>MIN_T_MAX, min_u>9, sec_t>5, sec_u>9) SHALL be clamped to that limit, per digit and independently.
REQ-018 start in IDLE or PAUSE with a nonzero count SHALL enter RUN on that edge; a tick on the same edge SHALL be ignored.
REQ-019 start with a count of 00:00 SHALL be ignored, and the state SHALL stay unchanged.
REQ-020 stop in RUN SHALL enter PAUSE on that edge; a tick on the same edge SHALL be ignored; stop in any other state SHALL have no effect.
REQ-021 start and stop high together SHALL resolve as stop (REQ-014).
REQ-022 In RUN, each tick SHALL decrement the count by one second, with borrow ripple on the same edge:
  - sec_u 0 -> 9, borrowing from sec_t;
  - sec_t 0 -> 5, borrowing from min_u;
  - min_u 0 -> 9, borrowing from min_t.
REQ-023 A tick that takes the count from 00:01 to 00:00 SHALL enter DONE on the same edge, with done_pulse high for exactly that next cycle.
REQ-024 The count SHALL never wrap below 00:00; ticks in IDLE, PAUSE and DONE SHALL be ignored.
REQ-025 DONE SHALL be held until clear or load; start in DONE SHALL be ignored (count is 00:00).
REQ-026 Decrement latency SHALL be 1 cycle: digits change on the edge that samples tick high.

Reset
REQ-027 clear high at a rising edge SHALL, in any state including mid-countdown, set:
  - the state to IDLE;
  - all digits to 0;
  - running, done and done_pulse to 0.
REQ-028 clear SHALL override load, start, stop and tick asserted on the same edge.

Verification
REQ-029 Load 01:00, start, apply 1 tick -> 00:59 with running=1; after 59 more ticks -> 00:00, done=1, done_pulse high for exactly 1 cycle, running=0.
REQ-030 Load 10:00, start, apply 1 tick -> 09:59; load ld_min_t=7, ld_sec_t=7 with MIN_T_MAX=5 -> loaded digits 5 and 5.
REQ-031 Load 00:05, start, 2 ticks -> 00:03; stop -> PAUSE; 3 ticks -> stays 00:03; start -> RUN; 3 ticks -> DONE.
REQ-032 Load 00:00, start -> stays IDLE, running=0, done=0; load during RUN -> ignored, count unchanged.
REQ-033 Mid-RUN at 02:30, assert clear together with tick and load -> next cycle all digits 0, IDLE, all flags 0.
REQ-034 Start and tick on the same edge -> count unchanged; stop and start together in RUN -> PAUSE.
